imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Issues one word write per instruction into the instruction memory write port, at byte addresses 0, 4, 8, …
- Holds the CPU in reset until a complete image with a correct checksum has been written.
- Sits between the boot/debug byte source and the instruction memory.

Parameters:
- ADDR_WIDTH, 10, byte-address width of the memory write port (word index = addr >> 2).
- DEPTH, 256, number of 32-bit words in the instruction memory.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE or DONE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  one-cycle memory write strobe.
- wr_addr  output  ADDR_WIDTH  byte address of the write; always a multiple of 4.
- wr_data  output  32  instruction word.
- busy  output  1  load in progress.
- done  output  1  level; last load completed, checksum good.
- err  output  1  level; last load completed, checksum bad.
- cpu_hold  output  1  CPU reset request.

Behaviour:
- Reset (rst_n=0 at a clk edge) values: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, cpu_hold=1.
- Reset mid-load aborts the load immediately. Words already written are left in memory.
- A byte transfer occurs on a clk edge where in_valid and in_ready are both 1. The source may hold in_valid high across cycles. The loader never stalls once in_ready is asserted.
- States and transitions:
  - IDLE: in_ready=0. On start, go to HDR; set busy=1, done=0, err=0, cpu_hold=1; clear byte counter, word counter and checksum.
  - HDR: in_ready=1. One accepted byte gives N = byte+1 words (1..256). Go to LOAD.
  - LOAD: in_ready=1. Each accepted byte shifts into the word register, MSB first: the first byte of a word is bits 31:24, the fourth is bits 7:0. The checksum is the XOR of every data byte.
    - On acceptance of the 4th byte, on the next cycle: wr_en=1, wr_data=word, wr_addr=word_index*4. Latency from the 4th-byte edge to wr_en high is 1 cycle.
    - Accepting the 4th byte of word N-1 moves the FSM to CHK.
  - CHK: in_ready=1. One accepted byte is compared with the XOR checksum.
    - Equal: done=1, err=0, cpu_hold=0.
    - Not equal: err=1, done=0, cpu_hold stays 1.
    - Either way go to DONE; busy=0 on the same edge.
  - DONE: in_ready=0. start begins a new load exactly as from IDLE.
- start is ignored in HDR, LOAD and CHK.
- If N exceeds DEPTH, the word index wraps modulo DEPTH. The address is formed as a truncated ADDR_WIDTH-bit value and wraps to 0.
- The last data word's wr_en pulse coincides with the first cycle of CHK. This is legal, because the checksum byte cannot arrive on the same edge.
- in_valid while in_ready=0: no byte is consumed and no state changes.

Decomposition:
- Shared package: state encoding (IDLE, HDR, LOAD, CHK, DONE) and the constants WORD_BYTES=4 and HDR_BYTES=1. The CPU top and the bench reuse these.
- One natural sub-module: imem_word_packer (byte shift register, 2-bit byte counter, word-complete pulse).
- The FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Reset then idle: after rst_n low for 2 cycles, cpu_hold=1, in_ready=0, wr_en=0; in_valid=1 with no start produces no writes.
- Single word: start, bytes 00 | 20 08 00 05 | checksum 2D. Expect one write wr_addr=0 wr_data=32'h20080005, then done=1, err=0, cpu_hold=0.
- Three words with in_valid gaps: header 02, words 11111111 22222222 33333333, checksum 00. Expect writes at addresses 0, 4, 8 with those data, each 1 cycle after its 4th byte, then done=1.
- Bad checksum: same as the single-word case but checksum 2C. Expect the word still written, err=1, done=0, cpu_hold=1; a following start clears err and restarts at addr 0.
- Reset mid-load: assert rst_n=0 after 6 data bytes of a 2-word load. Expect exactly one write issued, then all reset values; the next load starts at addr 0.
- Start while busy: pulse start during LOAD. Expect no effect on counters or addresses, and the load completes normally.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and
// image framing constants, also reused by the CPU top and the bench.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_CHK,
        ST_DONE
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int HDR_BYTES  = 1;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream; word_done flags the
// byte that completes a word, with the full word presented on the same cycle.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    // The completing byte is merged combinationally so the top can register
    // the word on the very edge that accepts the 4th byte.
    assign word      = {shift_q, byte_in};
    assign word_done = byte_en && (cnt_q == LAST_BYTE);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_en) begin
            shift_q <= {shift_q[15:0], byte_in};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory writer: header byte (N-1), 4*N data bytes, XOR checksum
// byte; holds the CPU in reset until an image with a good checksum lands.
//
// state   | meaning
// IDLE    | no load since reset, waiting for start
// HDR     | waiting for the word-count byte
// LOAD    | streaming data bytes, one memory write per completed word
// CHK     | waiting for the checksum byte
// DONE    | load finished (done or err set), start reloads
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_hold
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           state;
    logic [7:0]       words_left;
    logic [IDX_W-1:0] word_idx;
    logic [7:0]       csum;
    logic             xfer;
    logic             start_ok;
    logic [31:0]      word;
    logic             word_done;

    assign xfer     = in_valid && in_ready;
    assign start_ok = start && (state == ST_IDLE || state == ST_DONE);

    imem_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .byte_en   (xfer && state == ST_LOAD),
        .byte_in   (in_data),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
            words_left <= '0;
            word_idx   <= '0;
            csum       <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state    <= ST_HDR;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        word_idx <= '0;
                        csum     <= '0;
                    end
                end
                ST_HDR: begin
                    // words_left is a down-counter of words still to come after the current one
                    if (xfer) begin
                        words_left <= in_data;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        csum <= csum ^ in_data;
                        if (word_done) begin
                            wr_en    <= 1'b1;
                            wr_data  <= word;
                            wr_addr  <= ADDR_WIDTH'({word_idx, 2'b00});
                            word_idx <= (word_idx == IDX_W'(DEPTH - 1)) ? '0 : word_idx + 1'b1;
                            if (words_left == 8'd0)
                                state <= ST_CHK;
                            else
                                words_left <= words_left - 8'd1;
                        end
                    end
                end
                ST_CHK: begin
                    if (xfer) begin
                        state    <= ST_DONE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == csum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a byte-position reference model,
// plus literal expectations for the directed image scenarios.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_WIDTH = 10;
    localparam int DEPTH      = 256;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [7:0]            in_data = 8'h00;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  busy, done, err, cpu_hold;

    imem_loader #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks the position of each accepted byte in the image
    // (0 = header, 1..4N = data, 4N+1 = checksum).
    bit          m_active = 0;
    bit          m_busy = 0, m_done = 0, m_err = 0, m_hold = 1;
    bit          m_wr_en = 0;
    int          m_pos = 0, m_n = 0, m_nwr = 0;
    logic [7:0]  m_csum = 0;
    logic [31:0] m_word = 0, m_data = 0;
    logic [31:0] m_addr = 0;

    always @(posedge clk) begin
        m_wr_en = 0;
        if (!rst_n) begin
            m_active = 0; m_busy = 0; m_done = 0; m_err = 0; m_hold = 1;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_busy = 1; m_done = 0; m_err = 0; m_hold = 1;
                m_pos = 0; m_csum = 0;
            end
        end else if (in_valid) begin
            if (m_pos == 0) begin
                m_n = int'(in_data) + 1;
            end else if (m_pos <= 4 * m_n) begin
                m_csum ^= in_data;
                m_word = {m_word[23:0], in_data};
                if ((m_pos - 1) % 4 == 3) begin
                    m_wr_en = 1;
                    m_addr  = ((((m_pos - 1) / 4) % DEPTH) * 4) % (1 << ADDR_WIDTH);
                    m_data  = m_word;
                    m_nwr++;
                end
            end else begin
                m_active = 0; m_busy = 0;
                if (in_data == m_csum) begin m_done = 1; m_hold = 0; end
                else m_err = 1;
            end
            m_pos++;
        end
    end

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t log_q[$];

    always @(negedge clk) begin
        if (wr_en) log_q.push_back('{32'(wr_addr), wr_data});
        if (cmp_en) begin
            check("in_ready", 32'(in_ready), 32'(m_active));
            check("wr_en", 32'(wr_en), 32'(m_wr_en));
            if (m_wr_en) begin
                check("wr_addr", 32'(wr_addr), m_addr);
                check("wr_data", wr_data, m_data);
            end
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("err", 32'(err), 32'(m_err));
            check("cpu_hold", 32'(cpu_hold), 32'(m_hold));
        end
    end

    logic [7:0] img[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 0;
                in_data  = 8'($urandom);
                tick();
            end
        end
        in_valid = 1;
        in_data  = b;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL handshake_timeout: byte %0h never accepted", b);
        end
        in_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic run_load(input bit bad, input bit gaps, input int busy_start_at);
        logic [7:0] cs = 8'h00;
        int n = img.size() / 4;
        foreach (img[i]) cs ^= img[i];
        pulse_start();
        send_byte(8'(n - 1), gaps);
        for (int i = 0; i < img.size(); i++) begin
            if (i == busy_start_at) pulse_start();
            send_byte(img[i], gaps);
        end
        send_byte(bad ? (cs ^ 8'h01) : cs, gaps);
    endtask

    task automatic set_word_img(input logic [31:0] w[$]);
        img.delete();
        foreach (w[i]) for (int k = 3; k >= 0; k--) img.push_back(w[i][8*k +: 8]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        logic [31:0] ws[$];

        // Reset then idle
        rst_n = 0;
        tick(); tick();
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1;
        cmp_en = 1;
        in_valid = 1; in_data = 8'hA5;
        repeat (5) tick();
        in_valid = 0;
        check("idle_no_writes", 32'(log_q.size()), 32'd0);

        // Single word, good checksum (2D)
        log_q.delete();
        ws = '{32'h20080005};
        set_word_img(ws);
        run_load(0, 0, -1);
        check("single_nwr", 32'(log_q.size()), 32'd1);
        check("single_addr", log_q[0].addr, 32'd0);
        check("single_data", log_q[0].data, 32'h20080005);
        check("model_single_data", m_data, 32'h20080005);
        check("single_done", 32'(done), 32'd1);
        check("single_err", 32'(err), 32'd0);
        check("single_hold", 32'(cpu_hold), 32'd0);

        // Three words with gaps, checksum 00
        log_q.delete();
        ws = '{32'h11111111, 32'h22222222, 32'h33333333};
        set_word_img(ws);
        run_load(0, 1, -1);
        check("three_nwr", 32'(log_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("three_addr", log_q[i].addr, 32'(4 * i));
            check("three_data", log_q[i].data, ws[i]);
        end
        check("three_done", 32'(done), 32'd1);

        // Bad checksum (2C), then restart clears err and starts at 0
        log_q.delete();
        ws = '{32'h20080005};
        set_word_img(ws);
        run_load(1, 0, -1);
        check("bad_nwr", 32'(log_q.size()), 32'd1);
        check("bad_data", log_q[0].data, 32'h20080005);
        check("bad_err", 32'(err), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_hold", 32'(cpu_hold), 32'd1);
        log_q.delete();
        ws = '{32'hDEADBEEF, 32'h01020304};
        set_word_img(ws);
        run_load(0, 1, -1);
        check("restart_addr0", log_q[0].addr, 32'd0);
        check("restart_addr1", log_q[1].addr, 32'd4);
        check("restart_done", 32'(done), 32'd1);

        // Reset mid-load after 6 data bytes of a 2-word image
        log_q.delete();
        pulse_start();
        send_byte(8'h01, 0);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 0);
        rst_n = 0;
        tick(); tick();
        check("midrst_nwr", 32'(log_q.size()), 32'd1);
        check("midrst_data", log_q[0].data, 32'h01020304);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd1);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        rst_n = 1;
        tick();
        log_q.delete();
        ws = '{32'hCAFEF00D};
        set_word_img(ws);
        run_load(0, 0, -1);
        check("after_rst_addr", log_q[0].addr, 32'd0);

        // Start pulsed during LOAD is ignored
        log_q.delete();
        ws = '{32'hAAAA5555, 32'h12345678, 32'h87654321};
        set_word_img(ws);
        run_load(0, 1, 5);
        check("busy_start_nwr", 32'(log_q.size()), 32'd3);
        check("busy_start_addr2", log_q[2].addr, 32'd8);
        check("busy_start_done", 32'(done), 32'd1);

        // Random images, including the maximum 256-word image
        for (int r = 0; r < 6; r++) begin
            nw = (r == 5) ? 256 : $urandom_range(1, 40);
            img.delete();
            for (int i = 0; i < 4 * nw; i++) img.push_back(8'($urandom));
            log_q.delete();
            run_load(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 4 * nw + 10)));
            check("rand_nwr", 32'(log_q.size()), 32'(nw));
            if (nw == 256) check("max_last_addr", log_q[255].addr, 32'd1020);
        end

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
